// File: rtl/rv_fetch_pkg.sv
// Shared fetch types: opcode constants, queue entry layout and the
// immediate extractors the PC unit expects.
package rv_fetch_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int         JAL_OFF_W  = 21;
  localparam int         BR_OFF_W   = 13;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [JAL_OFF_W-1:0] jal_imm(input logic [31:0] i);
    return {i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [BR_OFF_W-1:0] br_imm(input logic [31:0] i);
    return {i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bundle: PC generator, instruction memory and decode handshakes.
// master = fetch engine side, slave = surrounding pipeline/memory side.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  import rv_fetch_pkg::*;

  logic [XLEN-1:0]      pc_addr;
  logic                 pc_stop;
  logic                 flush;
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [XLEN-1:0]      imem_req_addr;
  logic                 imem_rsp_valid;
  logic [XLEN-1:0]      imem_rsp_data;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [XLEN-1:0]      inst_data;
  logic [XLEN-1:0]      inst_pc;
  logic                 jal_hit;
  logic [JAL_OFF_W-1:0] jal_off;
  logic                 br_hit;
  logic [BR_OFF_W-1:0]  br_off;

  modport master (
    input  pc_addr, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output pc_stop, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
           jal_hit, jal_off, br_hit, br_off
  );

  modport slave (
    output pc_addr, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  pc_stop, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
           jal_hit, jal_off, br_hit, br_off
  );

endinterface

// File: rtl/ifu_fifo.sv
// Small instruction queue of {pc, inst} entries. Storage is not reset; only
// pointers and occupancy are, so the head is meaningful only when count != 0.
module ifu_fifo
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch engine: one outstanding memory request, queued responses,
// redirect flush with stale-response drop, and JAL/branch pre-decode on the head.
module ifu_fetch
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [CW-1:0] count;
  logic [CW:0]   free;
  logic          outstanding;
  logic          pop;
  logic          push;
  logic          accept;
  logic [XLEN-1:0] req_pc;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;
  logic [6:0]    opcode;

  assign outstanding = (state_q != S_IDLE);
  assign pop         = bus.inst_valid & bus.inst_ready;

  // Slots left once the in-flight response lands, counting a same-cycle pop.
  assign free = DEPTH_C - {1'b0, count} - {{CW{1'b0}}, outstanding} + {{CW{1'b0}}, pop};

  assign bus.imem_req_valid = !rst && !bus.flush && (free != '0) &&
                              (!outstanding || bus.imem_rsp_valid);
  assign bus.imem_req_addr  = bus.pc_addr;
  assign accept             = bus.imem_req_valid & bus.imem_req_ready;
  assign bus.pc_stop        = rst | (!accept & !bus.flush);

  assign push     = bus.imem_rsp_valid && (state_q == S_WAIT) && !bus.flush;
  assign wr_entry = '{pc: req_pc, inst: bus.imem_rsp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A response while idle is a protocol error and is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT, S_DROP: begin
        if (bus.imem_rsp_valid) state_d = accept ? S_WAIT : S_IDLE;
        else if (bus.flush)     state_d = S_DROP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) req_pc <= bus.pc_addr;
  end

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (bus.flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  // Decode-facing head and pre-decode, all gated by occupancy.
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = head.inst;
  assign bus.inst_pc    = head.pc;
  assign opcode         = head.inst[6:0];
  assign bus.jal_hit    = bus.inst_valid && (opcode == OPC_JAL);
  assign bus.br_hit     = bus.inst_valid && (opcode == OPC_BRANCH);
  assign bus.jal_off    = bus.inst_valid ? jal_imm(head.inst) : '0;
  assign bus.br_off     = bus.inst_valid ? br_imm(head.inst) : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: acts as PC generator, instruction memory and decode,
// predicts the instruction stream from a queue model and checks it at decode.
module tb_ifu_fetch;
  import rv_fetch_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if #(.XLEN(32)) bus ();

  ifu_fetch #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_on = 1'b0;

  // Memory / PC generator model state
  logic [31:0] next_pc = 32'h0;
  logic [31:0] flush_tgt = 32'h0;
  bit          pend = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  int          pend_wait = 0;
  int          pend_gen = 0;
  int          gen = 0;

  // Per-cycle knobs and observations
  bit k_flush = 1'b0, k_rr = 1'b0, k_ir = 1'b0;
  int k_lat = 0;
  bit last_acc, last_stop;
  int n_acc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] h;
    case (pc)
      32'h0:   return 32'h0080006F;
      32'h4:   return 32'hFE000EE3;
      32'h10:  return 32'hDEADBEEF;
      default: begin
        h = pc * 32'h9E3779B1;
        h = h ^ (h >> 15);
        case (h[1:0])
          2'd0:    return {h[31:7], 7'b1101111};
          2'd1:    return {h[31:7], 7'b1100011};
          default: return h;
        endcase
      end
    endcase
  endfunction

  function automatic logic [20:0] exp_jal(input logic [31:0] i);
    int v;
    v = (int'(i[31]) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
    return v[20:0];
  endfunction

  function automatic logic [12:0] exp_br(input logic [31:0] i);
    int v;
    v = (int'(i[31]) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
    return v[12:0];
  endfunction

  // Decode-side monitor: compares the presented head against the model queue.
  always @(negedge clk) begin
    if (!rst && mon_on) begin
      if (bus.inst_valid && !bus.flush) begin
        if (exp_q.size() == 0) begin
          chk("no_unexpected_inst", bus.inst_valid, 1'b0);
        end else begin
          mon_e = exp_q[0];
          chk("inst_pc", bus.inst_pc, mon_e.pc);
          chk("inst_data", bus.inst_data, mon_e.inst);
          chk("jal_hit", bus.jal_hit, mon_e.inst[6:0] == 7'b1101111);
          chk("br_hit", bus.br_hit, mon_e.inst[6:0] == 7'b1100011);
          chk("jal_off", bus.jal_off, exp_jal(mon_e.inst));
          chk("br_off", bus.br_off, exp_br(mon_e.inst));
          if (mon_e.inst == 32'h0080006F) chk("jal_plus8_off", bus.jal_off, 21'h8);
          if (mon_e.inst == 32'hFE000EE3) chk("beq_minus4_off", bus.br_off, 13'h1FFC);
          if (bus.inst_ready) void'(exp_q.pop_front());
        end
      end else if (!bus.inst_valid) begin
        chk("idle_jal_hit", bus.jal_hit, 1'b0);
        chk("idle_br_hit", bus.br_hit, 1'b0);
        chk("idle_offsets", {bus.jal_off, bus.br_off}, 34'h0);
      end
    end
  end

  task automatic cycle();
    bit acc, rsp_now, exp_rv;
    int free;
    @(posedge clk);
    #1;
    bus.pc_addr        = next_pc;
    bus.flush          = k_flush;
    bus.imem_req_ready = k_rr;
    bus.inst_ready     = k_ir;
    rsp_now = pend && (pend_wait == 0);
    if (pend && pend_wait > 0) pend_wait--;
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? mem_word(pend_pc) : $urandom;
    #1;
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    free = DEPTH - exp_q.size() - (pend ? 1 : 0) + ((bus.inst_valid && bus.inst_ready) ? 1 : 0);
    exp_rv = !k_flush && (free > 0) && (!pend || rsp_now);
    chk("req_valid", bus.imem_req_valid, exp_rv);
    chk("req_addr", bus.imem_req_addr, next_pc);
    chk("pc_stop", bus.pc_stop, !acc && !k_flush);
    last_acc  = acc;
    last_stop = bus.pc_stop;
    if (acc) n_acc++;
    if (rsp_now) begin
      pend = 1'b0;
      if (!k_flush && pend_gen == gen) exp_q.push_back('{pend_pc, bus.imem_rsp_data});
    end
    if (k_flush) begin
      exp_q.delete();
      gen++;
      next_pc = flush_tgt;
    end else if (acc) begin
      pend      = 1'b1;
      pend_pc   = next_pc;
      pend_gen  = gen;
      pend_wait = (k_lat < 0) ? int'($urandom_range(0, 2)) : k_lat;
      next_pc   = next_pc + 32'd4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bus.pc_addr        = 32'h0;
    bus.flush          = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_pc_stop", bus.pc_stop, 1'b1);
    chk("rst_hits", {bus.jal_hit, bus.br_hit}, 2'b00);
    chk("rst_offsets", {bus.jal_off, bus.br_off}, 34'h0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Steady stream, 1-cycle memory latency
    next_pc = 32'h0; k_rr = 1'b1; k_ir = 1'b1; k_lat = 0; k_flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i > 0) begin
        chk("steady_accept", last_acc, 1'b1);
        chk("steady_pc_stop", last_stop, 1'b0);
      end
    end

    // Backpressure fills the queue, then one pop frees exactly one request
    k_ir = 1'b0;
    repeat (6) cycle();
    chk("bp_req_blocked", bus.imem_req_valid, 1'b0);
    chk("bp_pc_stop", last_stop, 1'b1);
    chk("bp_full_valid", bus.inst_valid, 1'b1);
    n_acc = 0;
    k_ir = 1'b1;
    cycle();
    k_ir = 1'b0;
    repeat (5) cycle();
    chk("bp_one_request", n_acc, 1);

    k_ir = 1'b1; k_rr = 1'b0;
    repeat (4) cycle();
    chk("drained_empty", bus.inst_valid, 1'b0);

    // Memory stall
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc_stop", last_stop, 1'b1);
      chk("stall_req_valid", bus.imem_req_valid, 1'b1);
      chk("stall_no_push", bus.inst_valid, 1'b0);
    end

    // Flush with a fetch in flight
    k_flush = 1'b1; flush_tgt = 32'h10;
    cycle();
    k_flush = 1'b0; k_rr = 1'b1; k_lat = 1;
    cycle();
    chk("flush_accept", last_acc, 1'b1);
    chk("flush_req_addr", bus.imem_req_addr, 32'h10);
    k_flush = 1'b1; flush_tgt = 32'h40; k_lat = 0;
    cycle();
    chk("flush_cycle_pc_stop", last_stop, 1'b0);
    chk("flush_cycle_no_req", bus.imem_req_valid, 1'b0);
    k_flush = 1'b0;
    cycle();
    chk("redirect_addr", bus.imem_req_addr, 32'h40);
    chk("redirect_accept", last_acc, 1'b1);
    chk("stale_not_queued", bus.inst_valid, 1'b0);
    k_rr = 1'b0;
    cycle();
    chk("stale_not_queued2", bus.inst_valid, 1'b0);
    cycle();
    chk("redirect_inst_valid", bus.inst_valid, 1'b1);
    chk("redirect_inst_pc", bus.inst_pc, 32'h40);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      k_flush   = ($urandom_range(0, 19) == 0);
      flush_tgt = ($urandom_range(0, 3) == 0) ? 32'h0 : (r & 32'hFFFF_FFFC);
      k_rr      = ($urandom_range(0, 3) != 0);
      k_ir      = ($urandom_range(0, 2) != 0);
      k_lat     = -1;
      cycle();
    end
    k_flush = 1'b0; k_rr = 1'b0; k_ir = 1'b1;
    repeat (8) cycle();
    chk("random_drain_empty", bus.inst_valid, 1'b0);
    chk("random_all_consumed", exp_q.size(), 0);

    // Asynchronous reset with one entry queued and one request outstanding
    k_flush = 1'b1; flush_tgt = 32'h0;
    cycle();
    k_flush = 1'b0; k_rr = 1'b1; k_ir = 1'b0; k_lat = 3;
    repeat (5) cycle();
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready     = 1'b0;
    #1;
    chk("pre_rst_inst_valid", bus.inst_valid, 1'b1);
    chk("pre_rst_jal_hit", bus.jal_hit, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_inst_valid", bus.inst_valid, 1'b0);
    chk("async_rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("async_rst_jal_hit", bus.jal_hit, 1'b0);
    chk("async_rst_pc_stop", bus.pc_stop, 1'b1);
    exp_q.delete();
    pend = 1'b0;
    gen++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_pc = 32'h100;
    bus.pc_addr = next_pc;
    #1;
    chk("post_rst_req_valid", bus.imem_req_valid, 1'b1);
    chk("post_rst_req_addr", bus.imem_req_addr, 32'h100);
    k_rr = 1'b1; k_ir = 1'b1; k_lat = 0;
    cycle();
    chk("post_rst_accept", last_acc, 1'b1);
    repeat (4) cycle();
    k_rr = 1'b0;
    repeat (4) cycle();
    chk("final_empty", bus.inst_valid, 1'b0);
    chk("final_all_consumed", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
